// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with blanking gaps,
// leading-zero suppression and a frame-synchronous load/ack handshake.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 12500,
    parameter int unsigned BLANK_CYC = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        lzb,
    input  logic        enable,
    input  logic        load,
    output logic        load_ack,
    output logic [6:0]  led_out,
    output logic        dp_out,
    output logic [3:0]  dig_en_n,
    output logic        frame_start
);

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StDrive = 1'b1;
    localparam logic [15:0] CntLast  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] CntBlank = 16'(BLANK_CYC);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] pending_q, pending_d, shadow_q, shadow_d;
    logic [3:0]  pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
    logic        pend_v_q, pend_v_d;
    logic        slot_end, wrap;
    logic [3:0]  nib;
    logic        sup;
    logic [6:0]  led_d;
    logic        dp_d;
    logic [3:0]  dig_d;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'h40;
            4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;
            4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;
            4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;
            4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;
            4'h9: hex2seg = 7'h10;
            4'hA: hex2seg = 7'h08;
            4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;
            4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;
            default: hex2seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_end = (cnt_q == CntLast);
        wrap     = slot_end && (idx_q == 2'd3);
        cnt_d    = slot_end ? 16'd0 : cnt_q + 16'd1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        state_d  = (cnt_d >= CntBlank) ? StDrive : StBlank;

        // Transfer happens on the old pend_v, so a load on the wrap cycle waits a frame.
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_v_d    = pend_v_q;
        pending_d   = pending_q;
        pend_dp_d   = pend_dp_q;
        if (wrap && pend_v_q) begin
            shadow_d    = pending_q;
            shadow_dp_d = pend_dp_q;
            pend_v_d    = 1'b0;
        end
        if (load) begin
            pending_d = value_in;
            pend_dp_d = dp_in;
            pend_v_d  = 1'b1;
        end

        nib = 4'h0;
        sup = 1'b0;
        case (idx_q)
            2'd0: nib = shadow_q[3:0];
            2'd1: begin
                nib = shadow_q[7:4];
                sup = lzb && (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib = shadow_q[11:8];
                sup = lzb && (shadow_q[15:8] == 8'h00);
            end
            default: begin
                nib = shadow_q[15:12];
                sup = lzb && (shadow_q[15:12] == 4'h0);
            end
        endcase

        led_d = 7'h7F;
        dp_d  = 1'b1;
        dig_d = 4'hF;
        if (enable && (state_q == StDrive)) begin
            dig_d        = 4'hF;
            dig_d[idx_q] = 1'b0;
            led_d        = sup ? 7'h7F : hex2seg(nib);
            dp_d         = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            state_q     <= StBlank;
            pending_q   <= '0;
            pend_dp_q   <= '0;
            pend_v_q    <= 1'b0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            led_out     <= 7'h7F;
            dp_out      <= 1'b1;
            dig_en_n    <= 4'hF;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_dp_q   <= pend_dp_d;
            pend_v_q    <= pend_v_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            led_out     <= led_d;
            dp_out      <= dp_d;
            dig_en_n    <= dig_d;
            frame_start <= wrap;
            load_ack    <= wrap && pend_v_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle model pushes expected outputs at
// each clock edge, a monitor pops and compares them half a cycle later.
module tb_seg_scan_ctrl;

    localparam int SD  = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lzb, enable, load;
    logic        load_ack, dp_out, frame_start;
    logic [6:0]  led_out;
    logic [3:0]  dig_en_n;

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BLK)) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .lzb         (lzb),
        .enable      (enable),
        .load        (load),
        .load_ack    (load_ack),
        .led_out     (led_out),
        .dp_out      (dp_out),
        .dig_en_n    (dig_en_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] led;
        logic       dp;
        logic       fs;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt = 0;

    // Model state: m_p counts cycles since reset.
    int          m_p;
    logic [15:0] m_pend, m_shadow;
    logic [3:0]  m_pend_dp, m_shadow_dp;
    logic        m_pend_v;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    initial begin
        forever begin
            exp_t e;
            int   c, ix;
            logic wr;
            @(posedge clk);
            if (rst) begin
                m_p = 0; m_pend = '0; m_pend_dp = '0; m_pend_v = 1'b0;
                m_shadow = '0; m_shadow_dp = '0;
                e = '{dig: 4'hF, led: 7'h7F, dp: 1'b1, fs: 1'b0, ack: 1'b0};
            end else begin
                c  = m_p % SD;
                ix = (m_p / SD) % 4;
                wr = (c == SD - 1) && (ix == 3);
                e  = '{dig: 4'hF, led: 7'h7F, dp: 1'b1, fs: wr, ack: wr && m_pend_v};
                if (enable && c >= BLK) begin
                    logic [15:0] hi;
                    hi = m_shadow >> (4 * ix);
                    e.dig     = 4'hF;
                    e.dig[ix] = 1'b0;
                    e.led     = (lzb && ix != 0 && hi == 16'h0) ? 7'h7F : seg_of(hi[3:0]);
                    e.dp      = ~m_shadow_dp[ix];
                end
                if (wr && m_pend_v) begin
                    m_shadow = m_pend; m_shadow_dp = m_pend_dp; m_pend_v = 1'b0;
                end
                if (load) begin
                    m_pend = value_in; m_pend_dp = dp_in; m_pend_v = 1'b1;
                end
                m_p++;
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("dig_en_n",    16'(dig_en_n),    16'(e.dig));
            check("led_out",     16'(led_out),     16'(e.led));
            check("dp_out",      16'(dp_out),      16'(e.dp));
            check("frame_start", 16'(frame_start), 16'(e.fs));
            check("load_ack",    16'(load_ack),    16'(e.ack));
            if (load_ack) ack_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v; dp_in = d; load = 1'b1;
        cycles(1);
        load = 1'b0;
    endtask

    // Leaves the stimulus so that the next edge is a 3->0 wrap.
    task automatic wait_wrap_edge();
        int k;
        k = 0;
        while ((m_p % (4 * SD)) != 4 * SD - 1 && k < 8 * SD) begin
            cycles(1);
            k++;
        end
        check("wrap_wait_bound", 16'(k < 8 * SD), 16'd1);
    endtask

    initial begin
        int base;
        rst = 1'b1; value_in = '0; dp_in = '0; lzb = 1'b0; enable = 1'b1; load = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(70);

        // Mid-frame handshake
        cycles(5);
        do_load(16'h12AF, 4'b0100);
        cycles(80);

        // Overwrite before wrap: one ack only
        base = ack_cnt;
        cycles(3);
        do_load(16'h1111, 4'b0000);
        cycles(2);
        do_load(16'h2222, 4'b0000);
        cycles(40);
        check("overwrite_acks", 16'(ack_cnt - base), 16'd1);

        // Load on the exact wrap edge: deferred one frame
        wait_wrap_edge();
        base = ack_cnt;
        do_load(16'h3333, 4'b0000);
        cycles(4 * SD - 2);
        check("collision_no_ack", 16'(ack_cnt - base), 16'd0);
        cycles(6);
        check("collision_ack", 16'(ack_cnt - base), 16'd1);
        cycles(40);

        // Leading-zero blanking
        lzb = 1'b1;
        do_load(16'h0050, 4'b0000);
        cycles(70);
        do_load(16'h0000, 4'b0001);
        cycles(70);
        lzb = 1'b0;

        // Display dark for a frame
        enable = 1'b0;
        cycles(40);
        enable = 1'b1;
        cycles(10);

        // Reset with pending data: no ack afterwards, shadow cleared
        do_load(16'h4321, 4'b1111);
        cycles(2);
        base = ack_cnt;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(80);
        check("reset_drops_ack", 16'(ack_cnt - base), 16'd0);

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
